// File: rtl/bias_add_stage_pkg.sv
// Shared lane format for the bias-add path and the per-layer bias generators.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package bias_add_stage_pkg;

    // Default lane width and lane count. The fixed-point format matches the bias buses.
    localparam int LANE_W  = 18;
    localparam int N_LANES = 16;

    // Saturation limits for a LANE_W-bit two's complement lane.
    localparam logic [LANE_W-1:0] SAT_MAX = {1'b0, {(LANE_W-1){1'b1}}};
    localparam logic [LANE_W-1:0] SAT_MIN = {1'b1, {(LANE_W-1){1'b0}}};

    // Low bit index of lane 'lane' in a bus packed with 'width'-bit lanes.
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/bias_add_stage_sat_lane.sv
// Single-lane W+1 -> W signed saturation, optional ReLU, and a clamp flag.
// Latency: combinational.
// Backpressure: none; the enclosing pipeline decides when the result is captured.
module bias_sat_lane
    import bias_add_stage_pkg::*;
#(
    parameter int W       = LANE_W,
    parameter bit RELU_EN = 1'b1
) (
    input  logic [W:0]   sum,
    output logic [W-1:0] res,
    output logic         sat
);

    localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

    logic [W-1:0] clamped;

    // Clamp when the two top bits disagree, then zero negative results if ReLU is on.
    // The flag reflects clamping only, so a negative clamp is still reported after ReLU.
    always_comb begin
        clamped = sum[W-1:0];
        sat     = 1'b0;
        if (sum[W] != sum[W-1]) begin
            sat     = 1'b1;
            clamped = sum[W] ? MINV : MAXV;
        end
        res = clamped;
        if (RELU_EN && clamped[W-1]) begin
            res = '0;
        end
    end

endmodule

// File: rtl/bias_add_stage.sv
// Lane-wise bias add with signed saturation and optional ReLU over a valid/ready stream.
// Latency: 2 cycles from input transfer to out_valid; 1 vector/cycle throughput.
// Backpressure: a stalled output holds both stages; in_ready drops only when both are full.
module bias_add_stage
    import bias_add_stage_pkg::*;
#(
    parameter int N_adder_tree = N_LANES,
    parameter int W            = LANE_W,
    parameter bit RELU_EN      = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_adder_tree*W-1:0] in_data,
    input  logic [N_adder_tree*W-1:0] bias,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N_adder_tree*W-1:0] out_data,
    output logic [N_adder_tree-1:0]   sat_lanes,
    output logic [15:0]               sat_count
);

    localparam int SW = W + 1;

    logic                         s1_valid;
    logic                         s2_valid;
    logic [N_adder_tree*SW-1:0]   s1_sum;
    logic [N_adder_tree*SW-1:0]   sum_d;
    logic [N_adder_tree*W-1:0]    lane_res;
    logic [N_adder_tree-1:0]      lane_sat;
    logic                         s1_load;
    logic                         s2_load;

    // S2 can take new data when empty or draining; S1 likewise when S2 moves.
    // in_ready depends on out_ready and state only, never on in_valid.
    assign s2_load   = !s2_valid || out_ready;
    assign s1_load   = !s1_valid || s2_load;
    assign in_ready  = s1_load;
    assign out_valid = s2_valid;

    // Per-lane widening add feeding S1 and saturate/ReLU feeding S2.
    for (genvar i = 0; i < N_adder_tree; i++) begin : g_lane
        logic [W-1:0] a;
        logic [W-1:0] b;

        assign a = in_data[lane_lo(i, W) +: W];
        assign b = bias[lane_lo(i, W) +: W];
        assign sum_d[lane_lo(i, SW) +: SW] = {a[W-1], a} + {b[W-1], b};

        bias_sat_lane #(
            .W       (W),
            .RELU_EN (RELU_EN)
        ) u_sat (
            .sum (s1_sum[lane_lo(i, SW) +: SW]),
            .res (lane_res[lane_lo(i, W) +: W]),
            .sat (lane_sat[i])
        );
    end

    // Stage 1: capture the widened sums; bias is sampled here with in_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sum <= sum_d;
            end
        end
    end

    // Stage 2: capture saturated lanes and flags; held while the output is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            out_data  <= '0;
            sat_lanes <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_data  <= lane_res;
                sat_lanes <= lane_sat;
            end
        end
    end

    // Count delivered vectors with any clamped lane, sticking at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_count <= '0;
        end else if (s2_valid && out_ready && (|sat_lanes) && (sat_count != 16'hFFFF)) begin
            sat_count <= sat_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_bias_add_stage.sv
// Self-checking bench for bias_add_stage: directed steps plus random traffic vs a lane model.
// Latency: n/a.
// Backpressure: out_ready is driven by the bench in fixed and random patterns.
module tb_bias_add_stage;

    localparam int N  = 16;
    localparam int W  = 18;
    localparam int BW = N * W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [BW-1:0] in_data = '0;
    logic [BW-1:0] bias = '0;

    logic          in_ready, out_valid;
    logic [BW-1:0] out_data;
    logic [N-1:0]  sat_lanes;
    logic [15:0]   sat_count;

    logic          nr_in_ready, nr_out_valid;
    logic [BW-1:0] nr_out_data;
    logic [N-1:0]  nr_sat_lanes;
    logic [15:0]   nr_sat_count;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [BW-1:0] d_relu;
        logic [BW-1:0] d_lin;
        logic [N-1:0]  sat;
    } exp_t;

    exp_t q[$];
    int   exp_cnt = 0;

    always #5 clk = ~clk;

    bias_add_stage #(.N_adder_tree(N), .W(W), .RELU_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .bias(bias),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .sat_lanes(sat_lanes), .sat_count(sat_count)
    );

    bias_add_stage #(.N_adder_tree(N), .W(W), .RELU_EN(1'b0)) dut_nr (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(nr_in_ready), .in_data(in_data), .bias(bias),
        .out_valid(nr_out_valid), .out_ready(out_ready), .out_data(nr_out_data),
        .sat_lanes(nr_sat_lanes), .sat_count(nr_sat_count)
    );

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: integer add, clamp to the 18-bit signed range, then ReLU.
    function automatic exp_t model(input logic [BW-1:0] a, input logic [BW-1:0] b);
        exp_t e;
        logic signed [W-1:0] la, lb;
        int s, r;
        e.d_relu = '0;
        e.d_lin  = '0;
        e.sat    = '0;
        for (int i = 0; i < N; i++) begin
            la = a[i*W +: W];
            lb = b[i*W +: W];
            s  = int'(la) + int'(lb);
            if (s > 131071) begin
                r = 131071;
                e.sat[i] = 1'b1;
            end else if (s < -131072) begin
                r = -131072;
                e.sat[i] = 1'b1;
            end else begin
                r = s;
            end
            e.d_lin[i*W +: W]  = r[W-1:0];
            e.d_relu[i*W +: W] = (r < 0) ? '0 : r[W-1:0];
        end
        return e;
    endfunction

    function automatic logic [BW-1:0] rand_vec(input int mode);
        logic [BW-1:0] v;
        for (int i = 0; i < N; i++) begin
            if (mode == 0) v[i*W +: W] = W'($urandom_range(0, 4095)) - W'(2048);
            else           v[i*W +: W] = W'($urandom);
        end
        return v;
    endfunction

    // One clock: drive inputs after negedge, check outputs, account transfers, advance.
    task automatic cycle(input logic iv, input logic [BW-1:0] d, input logic [BW-1:0] b,
                         input logic ordy, output logic acc);
        exp_t e;
        in_valid  = iv;
        in_data   = d;
        bias      = b;
        out_ready = ordy;
        #1;
        check("in_ready", BW'(in_ready), BW'((q.size() < 2) || ordy));
        check("nr_out_valid", BW'(nr_out_valid), BW'(out_valid));
        if (out_valid) begin
            if (q.size() == 0) begin
                check("spurious_out_valid", BW'(out_valid), '0);
            end else begin
                check("out_data", out_data, q[0].d_relu);
                check("sat_lanes", BW'(sat_lanes), BW'(q[0].sat));
                check("nr_out_data", nr_out_data, q[0].d_lin);
                if (ordy) begin
                    e = q.pop_front();
                    if (e.sat != '0 && exp_cnt < 65535) exp_cnt++;
                end
            end
        end
        acc = iv && in_ready;
        if (acc) q.push_back(model(d, b));
        @(posedge clk);
        @(negedge clk);
        check("sat_count", BW'(sat_count), BW'(exp_cnt));
        check("nr_sat_count", BW'(nr_sat_count), BW'(exp_cnt));
    endtask

    task automatic drain();
        logic acc;
        int   n = 0;
        while (q.size() != 0 && n < 20) begin
            cycle(1'b0, '0, '0, 1'b1, acc);
            n++;
        end
        check("drain_remaining", BW'(q.size()), '0);
    endtask

    // Single vector into an empty pipe; checks the 2-cycle latency and leaves it at the output.
    task automatic directed(input logic [BW-1:0] d, input logic [BW-1:0] b);
        logic acc;
        cycle(1'b1, d, b, 1'b1, acc);
        check("dir_accept", BW'(acc), BW'(1));
        check("dir_lat1_valid", BW'(out_valid), '0);
        cycle(1'b0, '0, '0, 1'b0, acc);
        check("dir_lat2_valid", BW'(out_valid), BW'(1));
    endtask

    initial begin
        logic          acc;
        logic [BW-1:0] v, b;
        logic [BW-1:0] sv[8];
        logic [BW-1:0] sb[8];
        int            sent, c;

        // Reset state
        #1;
        check("rst_out_valid", BW'(out_valid), '0);
        check("rst_out_data", out_data, '0);
        check("rst_sat_lanes", BW'(sat_lanes), '0);
        check("rst_sat_count", BW'(sat_count), '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // T1: plain add in lane 0
        v = '0; b = '0;
        v[0 +: W] = 18'h00100;
        b[0 +: W] = 18'h008AB;
        directed(v, b);
        check("t1_lane0", BW'(out_data[0 +: W]), BW'(18'h009AB));
        check("t1_sat_lanes", BW'(sat_lanes), '0);
        drain();
        check("t1_sat_count", BW'(sat_count), '0);

        // T2: positive saturation in lane 3
        v = '0; b = '0;
        v[3*W +: W] = 18'h1F000;
        b[3*W +: W] = 18'h02000;
        directed(v, b);
        check("t2_lane3", BW'(out_data[3*W +: W]), BW'(18'h1FFFF));
        check("t2_sat3", BW'(sat_lanes[3]), BW'(1));
        drain();
        check("t2_sat_count", BW'(sat_count), BW'(1));

        // T3: negative saturation in lane 5 with and without ReLU
        v = '0; b = '0;
        v[5*W +: W] = 18'h20000;
        b[5*W +: W] = 18'h3FFFF;
        directed(v, b);
        check("t3_lane5_relu", BW'(out_data[5*W +: W]), '0);
        check("t3_sat5", BW'(sat_lanes[5]), BW'(1));
        check("t3_lane5_lin", BW'(nr_out_data[5*W +: W]), BW'(18'h20000));
        drain();

        // T4: 8-vector stream with out_ready pattern 1,0,0
        for (int k = 0; k < 8; k++) begin
            sv[k] = rand_vec(k % 2);
            sb[k] = rand_vec(1);
        end
        sent = 0;
        c    = 0;
        while (sent < 8 && c < 100) begin
            cycle(1'b1, sv[sent], sb[sent], (c % 3) == 0, acc);
            if (acc) sent++;
            c++;
        end
        check("t4_all_sent", BW'(sent), BW'(8));
        c = 0;
        while (q.size() != 0 && c < 60) begin
            cycle(1'b0, '0, '0, (c % 3) == 0, acc);
            c++;
        end
        check("t4_drained", BW'(q.size()), '0);

        // Random traffic and backpressure
        for (int k = 0; k < 300; k++) begin
            cycle(1'($urandom_range(0, 1)), rand_vec(k % 3 == 0 ? 0 : 1), rand_vec(1),
                  1'($urandom_range(0, 3) != 0), acc);
        end
        drain();

        // T5: asynchronous reset with two vectors in flight
        cycle(1'b1, rand_vec(1), rand_vec(1), 1'b1, acc);
        cycle(1'b1, rand_vec(1), rand_vec(1), 1'b1, acc);
        check("t5_pre_valid", BW'(out_valid), BW'(1));
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check("t5_rst_valid", BW'(out_valid), '0);
        check("t5_rst_count", BW'(sat_count), '0);
        check("t5_rst_data", out_data, '0);
        check("t5_rst_sat", BW'(sat_lanes), '0);
        q.delete();
        exp_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        c = 0;
        while (out_valid && c < 4) begin
            cycle(1'b0, '0, '0, 1'b1, acc);
            c++;
        end
        check("t5_no_partial", BW'(c), '0);
        directed(rand_vec(1), rand_vec(1));
        drain();

        // T6: saturating stream until the counter sticks
        v = '0; b = '0;
        v[0 +: W] = 18'h1FFFF;
        b[0 +: W] = 18'h00001;
        for (int k = 0; k < 65540; k++) begin
            cycle(1'b1, v, b, 1'b1, acc);
        end
        drain();
        check("t6_count_max", BW'(sat_count), BW'(16'hFFFF));
        directed(v, b);
        drain();
        check("t6_count_hold", BW'(sat_count), BW'(16'hFFFF));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
